// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer-side transmit scheduler:
// FSM encoding, header sync pattern and the header builder.
package serdes_pkg;

    // One-hot state encoding, same style as the downstream PISO FSM.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        HDR  = 3'b010,
        PAY  = 3'b100
    } state_t;

    // Upper five bits of every packet header byte.
    localparam logic [4:0] HDR_SYNC = 5'b10100;

    // Header byte: sync pattern followed by the 3-bit channel id.
    function automatic logic [7:0] build_hdr(input logic [2:0] id);
        return {HDR_SYNC, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... (mod NUM_CH)
// and returns a one-hot grant for the first requesting channel.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDW    = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDW-1:0]    ptr,
    output logic [NUM_CH-1:0] grant
);

    logic [IDW-1:0] idx;
    logic           found;

    // Walk the channels starting just after the last owner; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = IDW'((int'(ptr) + i) % NUM_CH);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serdes_tx_sched.sv
// Packet-level round-robin scheduler feeding one PISO serializer.
// Each granted packet goes out as a header byte {HDR_SYNC, id} followed
// by the channel's payload bytes, cut short after MAX_LEN payload bytes.
//
// Handshake rule (both sides): a byte moves on a rising pclk_i edge where
// valid and ready are both high. data_o/valid_o are registered and held
// until accepted; the output slot is free when !valid_o || ready_i, and
// req_ready_o is derived combinationally from that so the upstream byte
// is only taken when it can be loaded into the slot on the same edge.
module serdes_tx_sched
    import serdes_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                pclk_i,
    input  logic                rst_i,
    input  logic [NUM_CH-1:0]   en_i,
    input  logic [NUM_CH*8-1:0] req_data_i,
    input  logic [NUM_CH-1:0]   req_valid_i,
    input  logic [NUM_CH-1:0]   req_last_i,
    output logic [NUM_CH-1:0]   req_ready_o,
    output logic [7:0]          data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [NUM_CH-1:0]   grant_o,
    output logic                busy_o,
    output logic                trunc_o,
    output logic [2:0]          state_o
);

    localparam int IDW = $clog2(NUM_CH);

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    arb_id;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] arb_grant;
    logic [7:0]        beat_cnt;
    logic [7:0]        ch_data [NUM_CH];
    logic              slot_free;
    logic              beat;
    logic              end_pkt;

    // Split the flat payload bus into one byte per channel.
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_unpack
            assign ch_data[k] = req_data_i[8*k +: 8];
        end
    endgenerate

    assign eligible    = req_valid_i & en_i;
    assign slot_free   = !valid_o || ready_i;
    assign req_ready_o = (state == PAY && slot_free) ? grant_o : '0;
    assign beat        = |(req_ready_o & req_valid_i);
    assign end_pkt     = req_last_i[grant_id] || ((beat_cnt + 8'd1) == 8'(MAX_LEN));
    assign state_o     = state;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDW    (IDW)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    // Encode the arbiter's one-hot grant into a channel index.
    always_comb begin
        arb_id = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) arb_id = IDW'(i);
        end
    end

    // Scheduler FSM with registered outputs toward the PISO.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            data_o   <= '0;
            valid_o  <= 1'b0;
            grant_o  <= '0;
            grant_id <= '0;
            busy_o   <= 1'b0;
            trunc_o  <= 1'b0;
            beat_cnt <= '0;
            ptr      <= IDW'(NUM_CH - 1);
        end else begin
            trunc_o <= 1'b0;
            // Accepted byte leaves the slot unless a new one is loaded below.
            if (valid_o && ready_i) valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        grant_o  <= arb_grant;
                        grant_id <= arb_id;
                        busy_o   <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (slot_free) begin
                        data_o   <= build_hdr(3'(grant_id));
                        valid_o  <= 1'b1;
                        beat_cnt <= '0;
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (beat) begin
                        data_o   <= ch_data[grant_id];
                        valid_o  <= 1'b1;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (end_pkt) begin
                            // A real last byte takes precedence over the length cut.
                            trunc_o <= !req_last_i[grant_id];
                            ptr     <= grant_id;
                            grant_o <= '0;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
